// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU op sequencer: opcodes, ALU selects, FSM states.
package alu_ctrl_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;

   localparam logic [1:0] SEL_AND = 2'b00;
   localparam logic [1:0] SEL_OR  = 2'b01;
   localparam logic [1:0] SEL_ADD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_MUL  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return (op <= OP_MUL);
   endfunction

endpackage

// File: rtl/alu_mul_dp.sv
// Shift-add multiply datapath: multiplicand M, partial product HI:LO and the
// iteration counter. The add itself happens in the external ALU.
module alu_mul_dp #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_alu_out,
   input  logic             i_alu_cout,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_m,
   output logic [WIDTH-1:0] o_hi_nxt,
   output logic [WIDTH-1:0] o_lo_nxt,
   output logic             o_last
);

   logic [WIDTH-1:0] r_m, r_hi, r_lo;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH:0]   w_s;

   // LO[0] is the current multiplier bit; the 65-bit {S, LO} shifts right by one.
   assign w_s      = r_lo[0] ? {i_alu_cout, i_alu_out} : {1'b0, r_hi};
   assign o_hi_nxt = w_s[WIDTH:1];
   assign o_lo_nxt = {w_s[0], r_lo[WIDTH-1:1]};
   assign o_last   = (r_cnt == CNT_W'(WIDTH-1));
   assign o_hi     = r_hi;
   assign o_m      = r_m;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m   <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_m   <= i_a;
         r_hi  <= '0;
         r_lo  <= i_b;
         r_cnt <= '0;
      end else if (i_step) begin
         r_hi  <= o_hi_nxt;
         r_lo  <= o_lo_nxt;
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller driving a shared external ALU: single-pass logic/arith
// ops in one EXEC cycle, unsigned MUL as WIDTH shift-add iterations.
module alu_op_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry,
   output logic             err,
   output logic [1:0]       alu_sel,
   output logic             alu_binv,
   output logic             alu_cin,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_cout
);

   state_t           r_state, w_next;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a, r_b;
   logic             w_accept, w_legal, w_last;
   logic [WIDTH-1:0] w_hi, w_m, w_hi_nxt, w_lo_nxt;

   assign w_accept = (r_state == ST_IDLE) && start;
   assign w_legal  = op_legal(r_op);
   assign busy     = (r_state != ST_IDLE);
   assign done     = (r_state == ST_DONE);

   alu_mul_dp #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul_dp (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_accept && (op == OP_MUL)),
      .i_step     (r_state == ST_MUL),
      .i_a        (a),
      .i_b        (b),
      .i_alu_out  (alu_out),
      .i_alu_cout (alu_cout),
      .o_hi       (w_hi),
      .o_m        (w_m),
      .o_hi_nxt   (w_hi_nxt),
      .o_lo_nxt   (w_lo_nxt),
      .o_last     (w_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      alu_sel  = SEL_AND;
      alu_binv = 1'b0;
      alu_cin  = 1'b0;
      alu_in1  = '0;
      alu_in2  = '0;
      case (r_state)
         ST_IDLE: if (start) w_next = (op == OP_MUL) ? ST_MUL : ST_EXEC;
         ST_EXEC: begin
            // Illegal ops keep the ALU at its idle drive.
            if (w_legal) begin
               alu_in1 = r_a;
               alu_in2 = r_b;
               case (r_op)
                  OP_OR:   alu_sel = SEL_OR;
                  OP_ADD:  alu_sel = SEL_ADD;
                  OP_SUB: begin
                     alu_sel  = SEL_ADD;
                     alu_binv = 1'b1;
                     alu_cin  = 1'b1;
                  end
                  default: alu_sel = SEL_AND;
               endcase
            end
            w_next = ST_DONE;
         end
         ST_MUL: begin
            alu_in1 = w_hi;
            alu_in2 = w_m;
            alu_sel = SEL_ADD;
            if (w_last) w_next = ST_DONE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op <= '0;
         r_a  <= '0;
         r_b  <= '0;
      end else if (w_accept) begin
         r_op <= op;
         r_a  <= a;
         r_b  <= b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_lo <= '0;
         result_hi <= '0;
         carry     <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (start) err <= 1'b0;
            ST_EXEC: begin
               result_hi <= '0;
               if (w_legal) begin
                  result_lo <= alu_out;
                  carry     <= ((r_op == OP_ADD) || (r_op == OP_SUB)) && alu_cout;
               end else begin
                  result_lo <= '0;
                  carry     <= 1'b0;
                  err       <= 1'b1;
               end
            end
            ST_MUL: if (w_last) begin
               result_hi <= w_hi_nxt;
               result_lo <= w_lo_nxt;
               carry     <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural model of the shared ALU.
module tb_alu_op_sequencer;

   typedef struct {
      logic [63:0] prod;
      logic        c;
      logic        e;
      int          lat;
      int          scyc;
   } exp_t;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done, carry, err, alu_binv, alu_cin, alu_cout;
   logic [31:0] result_lo, result_hi, alu_in1, alu_in2, alu_out;
   logic [1:0]  alu_sel;
   logic [31:0] w_b2;
   logic [32:0] w_sum;

   exp_t q[$];
   int   cyc = 0;
   int   n_pass = 0, n_total = 0;

   alu_op_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
      .carry(carry), .err(err), .alu_sel(alu_sel), .alu_binv(alu_binv),
      .alu_cin(alu_cin), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_out(alu_out), .alu_cout(alu_cout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Shared ALU: AND / OR / ADD with optional B-invert and carry-in.
   always_comb begin
      alu_out  = '0;
      alu_cout = 1'b0;
      w_b2     = alu_binv ? ~alu_in2 : alu_in2;
      w_sum    = {1'b0, alu_in1} + {1'b0, w_b2} + {32'b0, alu_cin};
      case (alu_sel)
         2'b00:   alu_out = alu_in1 & w_b2;
         2'b01:   alu_out = alu_in1 | w_b2;
         default: {alu_cout, alu_out} = w_sum;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every done pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("result_lo", {32'b0, result_lo}, {32'b0, e.prod[31:0]});
            chk("result_hi", {32'b0, result_hi}, {32'b0, e.prod[63:32]});
            chk("carry", {63'b0, carry}, {63'b0, e.c});
            chk("err", {63'b0, err}, {63'b0, e.e});
            chk("latency", 64'(cyc - e.scyc), 64'(e.lat - 1));
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] prod, input logic c, input logic e, input int lat);
      exp_t ent;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'b001; a = ~x; b = ~y;
      ent.prod = prod; ent.c = c; ent.e = e; ent.lat = lat; ent.scyc = cyc;
      q.push_back(ent);
      // Now in the EXEC cycle for single-pass ops: check the ALU drive.
      if (o != 3'b100) begin
         logic [1:0] s;
         logic       inv;
         s   = (o == 3'b001) ? 2'b01 : ((o == 3'b010 || o == 3'b011) ? 2'b10 : 2'b00);
         inv = (o == 3'b011);
         if (o > 3'b100) begin
            x = '0; y = '0;
         end
         chk("exec_sel", {62'b0, alu_sel}, {62'b0, s});
         chk("exec_binv_cin", {62'b0, alu_binv, alu_cin}, {62'b0, inv, inv});
         chk("exec_in1", {32'b0, alu_in1}, {32'b0, x});
         chk("exec_in2", {32'b0, alu_in2}, {32'b0, y});
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("done_timeout", 64'(q.size()), 64'd0);
         q.delete();
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy_done", {62'b0, busy, done}, 64'd0);
      chk("rst_err_carry", {62'b0, err, carry}, 64'd0);
      chk("rst_result", {result_hi, result_lo}, 64'd0);
      chk("rst_alu", {alu_in1, alu_in2}, 64'd0);
      @(negedge clk) rst = 1'b0;

      issue(3'b000, 32'ha5a5a5a5, 32'h5a5a5a5a, 64'h0, 1'b0, 1'b0, 2);
      drain();
      issue(3'b010, 32'hffffffff, 32'h00000001, 64'h0, 1'b1, 1'b0, 2);
      drain();
      issue(3'b011, 32'h7, 32'h5, 64'h2, 1'b1, 1'b0, 2);
      drain();
      issue(3'b011, 32'h5, 32'h7, 64'h00000000_fffffffe, 1'b0, 1'b0, 2);
      drain();
      issue(3'b100, 32'hffffffff, 32'hffffffff, 64'hfffffffe_00000001, 1'b0, 1'b0, 33);
      drain();
      issue(3'b100, 32'h12345678, 32'h0, 64'h0, 1'b0, 1'b0, 33);
      drain();
      issue(3'b100, 32'h00000010, 32'h10000000, 64'h00000001_00000000, 1'b0, 1'b0, 33);
      drain();

      // start with another op during a MUL must be ignored
      issue(3'b100, 32'h00010001, 32'h0000ffff, 64'h00000000_ffffffff, 1'b0, 1'b0, 33);
      repeat (9) @(posedge clk);
      @(negedge clk);
      start = 1'b1; op = 3'b000; a = 32'h0; b = 32'h0;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_mid_mul", {63'b0, busy}, 64'd1);
      drain();
      repeat (4) @(posedge clk);
      #1;
      chk("result_held", {result_hi, result_lo}, 64'h00000000_ffffffff);

      // asynchronous reset in the middle of a MUL
      issue(3'b100, 32'h3, 32'h4, 64'hc, 1'b0, 1'b0, 33);
      repeat (9) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_busy_done", {62'b0, busy, done}, 64'd0);
      chk("arst_result", {result_hi, result_lo}, 64'd0);
      chk("arst_alu_in1", {32'b0, alu_in1}, 64'd0);
      q.delete();
      @(negedge clk) rst = 1'b0;

      issue(3'b001, 32'hf0f0f0f0, 32'h0f0f0f0f, 64'h00000000_ffffffff, 1'b0, 1'b0, 2);
      drain();
      issue(3'b111, 32'h12345678, 32'h9abcdef0, 64'h0, 1'b0, 1'b1, 2);
      drain();
      issue(3'b010, 32'h00000003, 32'h00000004, 64'h7, 1'b0, 1'b0, 2);
      drain();

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
